// File: rtl/reg_file_pkg.sv
// reg_file_pkg: default geometry and shared types for the multi-port register file
package reg_file_pkg;
   localparam int RF_DW      = 8;
   localparam int RF_AW      = 4;
   localparam int RF_NRD     = 2;
   localparam int RF_PCW     = 12;
   localparam int RF_ZERO_R0 = 0;
   typedef logic [RF_AW-1:0]  reg_addr_t;
   typedef logic [RF_DW-1:0]  reg_data_t;
   typedef logic [RF_PCW-1:0] pc_t;
endpackage

// File: rtl/rf_bypass_mux.sv
// rf_bypass_mux: one read port with ALU/load-return bypass and busy flag
module rf_bypass_mux #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic [AW-1:0] rd_addr,
   input  logic          zero,
   input  logic          wr_acc,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          ld_ret,
   input  logic [AW-1:0] ld_ret_addr,
   input  logic [DW-1:0] ld_ret_data,
   input  logic [DW-1:0] stored,
   input  logic          pend,
   output logic [DW-1:0] rd_data,
   output logic          rd_busy
);
   logic ret_hit;
   assign ret_hit = ld_ret && ld_ret_addr == rd_addr;
   // ALU write beats returning load, which beats the stored value; a returning load also frees the port
   always_comb begin
      rd_data = zero ? '0 : (wr_acc && wr_addr == rd_addr) ? wr_data : ret_hit ? ld_ret_data : stored;
      rd_busy = pend && !ret_hit;
   end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: dual-write, multi-read register file with load scoreboard and PC-gated ALU writes
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int DW      = RF_DW,
   parameter int AW      = RF_AW,
   parameter int NRD     = RF_NRD,
   parameter int PCW     = RF_PCW,
   parameter int ZERO_R0 = RF_ZERO_R0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_addr,
   input  logic [DW-1:0]      wr_data,
   input  logic [PCW-1:0]     prog_ctr,
   input  logic               ld_issue,
   input  logic [AW-1:0]      ld_addr,
   input  logic               ld_ret,
   input  logic [AW-1:0]      ld_ret_addr,
   input  logic [DW-1:0]      ld_ret_data,
   input  logic [NRD*AW-1:0]  rd_addr,
   output logic [NRD*DW-1:0]  rd_data,
   output logic [NRD-1:0]     rd_busy,
   output logic [2**AW-1:0]   pend_vec,
   output logic               err
);
   localparam int DEPTH = 2**AW;
   localparam bit ZR    = ZERO_R0 != 0;
   logic [DW-1:0]    mem [DEPTH];
   logic [DEPTH-1:0] pend, pend_nxt;
   logic [PCW-1:0]   last_pc;
   logic             pc_vld, wr_acc, wr_st, ret_st, iss_st, err_set;
   assign wr_acc   = wr_en && (!pc_vld || prog_ctr != last_pc);
   assign wr_st    = wr_acc && !(ZR && wr_addr == '0);
   assign ret_st   = ld_ret && !(ZR && ld_ret_addr == '0);
   assign iss_st   = ld_issue && !(ZR && ld_addr == '0);
   assign err_set  = iss_st && pend[ld_addr] && !(ld_ret && ld_ret_addr == ld_addr);
   assign pend_vec = pend;
   // a return clears its bit first so a same-cycle issue to that register leaves it pending
   always_comb begin
      pend_nxt = pend;
      if (ld_ret) pend_nxt[ld_ret_addr] = 1'b0;
      if (iss_st) pend_nxt[ld_addr] = 1'b1;
   end
   // storage: the ALU write is issued last so it wins a same-address collision with a load return
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      end else begin
         if (ret_st) mem[ld_ret_addr] <= ld_ret_data;
         if (wr_st) mem[wr_addr] <= wr_data;
      end
   end
   // scoreboard, sticky error and duplicate-write PC tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend    <= '0;
         err     <= 1'b0;
         pc_vld  <= 1'b0;
         last_pc <= '0;
      end else begin
         pend    <= pend_nxt;
         err     <= err || err_set;
         pc_vld  <= 1'b1;
         last_pc <= prog_ctr;
      end
   end
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      rf_bypass_mux #(.DW(DW), .AW(AW)) u_mux (
         .rd_addr     (rd_addr[i*AW +: AW]),
         .zero        (ZR && rd_addr[i*AW +: AW] == '0),
         .wr_acc      (wr_acc),
         .wr_addr     (wr_addr),
         .wr_data     (wr_data),
         .ld_ret      (ld_ret),
         .ld_ret_addr (ld_ret_addr),
         .ld_ret_data (ld_ret_data),
         .stored      (mem[rd_addr[i*AW +: AW]]),
         .pend        (pend[rd_addr[i*AW +: AW]]),
         .rd_data     (rd_data[i*DW +: DW]),
         .rd_busy     (rd_busy[i])
      );
   end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: scoreboard bench for reg_file_mp, plain and zero-register variants side by side
module tb_reg_file_mp;
   import reg_file_pkg::*;
   localparam int S_RD0 = 0, S_RD1 = 1, S_BUSY = 2, S_PEND = 3, S_ERR = 4;
   localparam int S_ZRD0 = 5, S_ZRD1 = 6, S_ZBUSY = 7, S_ZPEND = 8, S_ZERR = 9;
   logic      clk = 1'b0, rst_n;
   logic      wr_en, ld_issue, ld_ret;
   reg_addr_t wr_addr, ld_addr, ld_ret_addr, rd0, rd1;
   reg_data_t wr_data, ld_ret_data;
   pc_t       prog_ctr;
   logic [15:0] rd_data, z_rd_data, pend_vec, z_pend;
   logic [1:0]  rd_busy, z_busy;
   logic        err, z_err;
   int          n_vec = 0, n_bad = 0;
   string       tq[$];
   int          sq[$];
   logic [31:0] vq[$];
   always #5 clk = ~clk;
   reg_file_mp u_dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .prog_ctr(prog_ctr), .ld_issue(ld_issue), .ld_addr(ld_addr), .ld_ret(ld_ret),
      .ld_ret_addr(ld_ret_addr), .ld_ret_data(ld_ret_data), .rd_addr({rd1, rd0}),
      .rd_data(rd_data), .rd_busy(rd_busy), .pend_vec(pend_vec), .err(err)
   );
   reg_file_mp #(.ZERO_R0(1)) u_dut_z (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .prog_ctr(prog_ctr), .ld_issue(ld_issue), .ld_addr(ld_addr), .ld_ret(ld_ret),
      .ld_ret_addr(ld_ret_addr), .ld_ret_data(ld_ret_data), .rd_addr({rd1, rd0}),
      .rd_data(z_rd_data), .rd_busy(z_busy), .pend_vec(z_pend), .err(z_err)
   );
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask
   function automatic logic [31:0] obs(input int s);
      case (s)
         S_RD0:   return {24'd0, rd_data[7:0]};
         S_RD1:   return {24'd0, rd_data[15:8]};
         S_BUSY:  return {30'd0, rd_busy};
         S_PEND:  return {16'd0, pend_vec};
         S_ERR:   return {31'd0, err};
         S_ZRD0:  return {24'd0, z_rd_data[7:0]};
         S_ZRD1:  return {24'd0, z_rd_data[15:8]};
         S_ZBUSY: return {30'd0, z_busy};
         S_ZPEND: return {16'd0, z_pend};
         S_ZERR:  return {31'd0, z_err};
         default: return 32'hdead_beef;
      endcase
   endfunction
   task automatic want(input string tag, input int s, input logic [31:0] v);
      tq.push_back(tag);
      sq.push_back(s);
      vq.push_back(v);
   endtask
   task automatic settle();
      string t;
      int s;
      logic [31:0] v;
      #1;
      while (tq.size() > 0) begin
         t = tq.pop_front();
         s = sq.pop_front();
         v = vq.pop_front();
         chk(t, obs(s), v);
      end
   endtask
   task automatic idle();
      wr_en = 0; ld_issue = 0; ld_ret = 0;
      wr_addr = 0; wr_data = 0; ld_addr = 0; ld_ret_addr = 0; ld_ret_data = 0;
   endtask
   initial begin
      rst_n = 0; idle(); prog_ctr = 0; rd0 = 3; rd1 = 7;
      want("rst_rd0", S_RD0, 0); want("rst_rd1", S_RD1, 0); want("rst_busy", S_BUSY, 0);
      want("rst_pend", S_PEND, 0); want("rst_err", S_ERR, 0);
      settle();
      wr_en = 1; wr_addr = 3; wr_data = 8'h5A;
      @(negedge clk); rst_n = 1;
      want("first_wr_byp", S_RD0, 8'h5A); settle();
      @(negedge clk); wr_data = 8'hA5;
      want("same_pc_block", S_RD0, 8'h5A); settle();
      @(negedge clk);
      want("same_pc_block2", S_RD0, 8'h5A); settle();
      @(negedge clk); prog_ctr = 12'h010; wr_data = 8'h5A;
      want("pc010_wr", S_RD0, 8'h5A); settle();
      @(negedge clk); wr_data = 8'hA5;
      want("pc010_block", S_RD0, 8'h5A); settle();
      @(negedge clk);
      want("pc010_block2", S_RD0, 8'h5A); settle();
      @(negedge clk); prog_ctr = 12'h011;
      want("pc_adv_byp", S_RD0, 8'hA5); settle();
      @(negedge clk); wr_en = 0;
      want("pc_adv_store", S_RD0, 8'hA5); settle();
      @(negedge clk); ld_issue = 1; ld_addr = 7;
      want("issue_busy", S_BUSY, 0); want("issue_pend", S_PEND, 0); settle();
      @(negedge clk); idle();
      want("pend7_busy", S_BUSY, 2'b10); want("pend7_vec", S_PEND, 16'h0080);
      want("pend7_zbusy", S_ZBUSY, 2'b10); settle();
      @(negedge clk); settle();
      @(negedge clk); ld_ret = 1; ld_ret_addr = 7; ld_ret_data = 8'h3C;
      want("ret_byp", S_RD1, 8'h3C); want("ret_busy", S_BUSY, 0);
      want("ret_pend_hold", S_PEND, 16'h0080); want("ret_zbyp", S_ZRD1, 8'h3C); settle();
      @(negedge clk); idle();
      want("ret_pend_clr", S_PEND, 0); want("ret_store", S_RD1, 8'h3C); settle();
      @(negedge clk); ld_issue = 1; ld_addr = 5; rd0 = 5;
      want("reg5_init", S_RD0, 0); settle();
      @(negedge clk); idle(); wr_en = 1; wr_addr = 5; wr_data = 8'h11; prog_ctr = 12'h012;
      ld_ret = 1; ld_ret_addr = 5; ld_ret_data = 8'h22;
      want("cfl_byp", S_RD0, 8'h11); want("cfl_busy", S_BUSY, 0);
      want("cfl_pend_pre", S_PEND, 16'h0020); settle();
      @(negedge clk); idle();
      want("cfl_store", S_RD0, 8'h11); want("cfl_pend", S_PEND, 0); settle();
      @(negedge clk); ld_issue = 1; ld_addr = 6; settle();
      @(negedge clk); ld_ret = 1; ld_ret_addr = 6; ld_ret_data = 8'h66; rd1 = 6;
      want("iss_ret_pend", S_PEND, 16'h0040); want("iss_ret_busy", S_BUSY, 0);
      want("iss_ret_byp", S_RD1, 8'h66); settle();
      @(negedge clk); idle();
      want("iss_ret_set", S_PEND, 16'h0040); want("iss_ret_noerr", S_ERR, 0);
      want("iss_ret_store", S_RD1, 8'h66); want("pend6_busy", S_BUSY, 2'b10); settle();
      @(negedge clk); ld_issue = 1; ld_addr = 6;
      want("err_pre", S_ERR, 0); settle();
      @(negedge clk); idle();
      want("err_set", S_ERR, 1); want("zerr_set", S_ZERR, 1); settle();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         want("err_sticky", S_ERR, 1); settle();
      end
      @(negedge clk); wr_en = 1; wr_addr = 0; wr_data = 8'hFF; prog_ctr = 12'h013; rd0 = 0;
      ld_issue = 1; ld_addr = 0;
      want("r0_byp", S_RD0, 8'hFF); want("zr0_byp", S_ZRD0, 0); settle();
      @(negedge clk); idle();
      want("r0_store", S_RD0, 8'hFF); want("zr0_store", S_ZRD0, 0);
      want("r0_pend", S_PEND, 16'h0041); want("zr0_pend", S_ZPEND, 16'h0040); settle();
      @(negedge clk); rd0 = 3;
      want("pre_rst_pend", S_PEND, 16'h0041); want("pre_rst_rd0", S_RD0, 8'hA5); settle();
      #2 rst_n = 0;
      want("arst_pend", S_PEND, 0); want("arst_err", S_ERR, 0); want("arst_rd0", S_RD0, 0);
      want("arst_rd1", S_RD1, 0); want("arst_busy", S_BUSY, 0); want("arst_zpend", S_ZPEND, 0);
      settle();
      @(negedge clk); rst_n = 1; ld_ret = 1; ld_ret_addr = 7; ld_ret_data = 8'h99; rd1 = 7;
      want("post_rst_byp", S_RD1, 8'h99); settle();
      @(negedge clk); idle();
      want("post_rst_store", S_RD1, 8'h99); want("post_rst_err", S_ERR, 0);
      want("post_rst_pend", S_PEND, 0); settle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
